commit_collector: RTL and testbench
===================================

Name: commit_collector

Overview:
- Downstream of the per-round verify commitment stage: captures the Ch/Cn/Cv digest triple produced for each parallel repetition t.
- Stores the triples in register arrays indexed by round.
- Once all T rounds are present, streams them as 64-bit words to the challenge-hash (HCP) input.
- Decouples out-of-order round completion from the strictly ordered hash absorb.

Parameters:
- T, 16, number of parallel repetitions collected (1..256)
- DIG_W, 256, width of each digest (Ch, Cn, Cv)
- OUT_W, 64, stream word width; DIG_W must be a multiple of OUT_W

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- clear  in  1  synchronous flush back to COLLECT; highest priority
- in_valid  in  1  digest triple valid
- in_ready  out  1  collector accepts a triple
- in_round  in  8  round index t of the triple
- in_ch  in  DIG_W  Ch digest
- in_cn  in  DIG_W  Cn digest
- in_cv  in  DIG_W  Cv digest
- collect_done  out  1  all T rounds written (level)
- stream_start  in  1  pulse: begin output stream
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts word
- out_data  out  OUT_W  stream word
- out_last  out  1  final word of stream, qualified by out_valid
- stream_end  out  1  one-cycle pulse after final handshake
- err_range  out  1  sticky: a triple arrived with in_round >= T
- err_dup  out  1  sticky duplicate-round flag (see Optional Feature)

Behaviour:
- Reset values: in_ready=0, collect_done=0, out_valid=0, out_data=0, out_last=0, stream_end=0, err_range=0, err_dup=0, state=COLLECT, written bitmap=0, word counter=0. Array contents undefined.
- The reset clause is the sole async term. Deassertion lets COLLECT begin on the next edge; in_ready rises one cycle after deassertion.
- FSM states:
  - COLLECT: in_ready=1.
  - FULL: in_ready=0, collect_done=1.
  - STREAM.
  - DONE: collect_done=1.
- COLLECT:
  - Handshake is in_valid & in_ready.
  - If in_round < T: write ch/cn/cv[in_round] and set bitmap[in_round].
  - If in_round >= T: drop the triple and set err_range.
  - Rewriting an index overwrites it; the last write wins.
  - Go to FULL the cycle after the bitmap becomes all-ones.
- FULL:
  - stream_start moves to STREAM.
  - stream_start in any other state is ignored.
- STREAM:
  - Word order: Ch[0..T-1], then Cn[0..T-1], then Cv[0..T-1].
  - Each digest is sent as DIG_W/OUT_W words, most-significant word first.
  - Total 3*T*DIG_W/OUT_W words (192 at defaults).
  - out_valid rises exactly one cycle after stream_start is sampled.
  - out_data is driven combinationally from the arrays at the current word counter.
  - The word counter advances on out_valid & out_ready.
  - out_data/out_last stay stable while out_valid & ~out_ready.
  - out_last=1 on the final word. After its handshake: out_valid=0, stream_end pulses the next cycle, go to DONE.
- DONE: holds until clear.
- clear (any state): next cycle state=COLLECT, bitmap=0, counter=0, out_valid=0, error flags=0. Arrays are not cleared.
- Simultaneous clear and in_valid: clear wins and the triple is not written.
- Reset mid-stream: all outputs return to reset values immediately, asynchronously.

Optional Feature:
- Macro COLLECT_DUP_CHECK_EN.
- Defined: a handshake with in_round < T whose bitmap bit is already set sets err_dup. The stored triple is NOT overwritten (first write wins).
- Undefined: err_dup is tied 0 and overwrite semantics apply.

Decomposition:
- Shared package: DIG_W/OUT_W defaults, FSM state encoding (2-bit: COLLECT=0, FULL=1, STREAM=2, DONE=3), word-count width function clog2(3*T*DIG_W/OUT_W).
- One natural sub-module: commit_word_sel. It is combinational: maps word counter to (array select, round index, word-in-digest) and performs the out_data mux.

Test Plan:
- Write rounds 0..15 in order with in_ch[t]=t, in_cn[t]=0x100+t, in_cv[t]=0x200+t (low bits, rest 0). Expect collect_done on the cycle after the 16th handshake. After stream_start: 192 words; word 3 = 0x0, word 4's low word = 1 at word index 7, out_last only on word 191, stream_end one cycle later.
- Write rounds in order 15 down to 0 -> identical stream to the previous case.
- Hold out_ready=0 for 5 cycles mid-stream at word 50 -> out_data stable; word 51 follows after out_ready=1; no words lost.
- in_round=16 -> err_range=1, triple dropped; collect_done not asserted until rounds 0..15 complete.
- Round 3 written twice (values A then B). Macro undefined -> stream carries B, err_dup=0. Macro defined -> stream carries A, err_dup=1.
- Assert reset low at word 100 -> out_valid=0 same cycle. Then clear/reset -> in_ready=1, bitmap empty, full re-collect required.

Source files
------------

// File: rtl/commit_collector_pkg.sv
// Shared definitions for the commit collector: digest/stream width
// defaults, FSM state encoding and the word-counter width helper.
package commit_collector_pkg;

  localparam int DIG_W_DEF = 256;
  localparam int OUT_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FULL    = 2'd1,
    ST_STREAM  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Bits needed to count every stream word: clog2(3*T*DIG_W/OUT_W), at least 1.
  function automatic int word_cnt_w(input int t, input int dig_w, input int out_w);
    int n;
    n = 3 * t * (dig_w / out_w);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/commit_collector_word_sel.sv
// Combinational stream word selector: splits the word counter into
// (digest array, round index, word within digest) and muxes out the
// addressed OUT_W slice, most-significant word of each digest first.
module commit_word_sel #(
  parameter int T     = 16,
  parameter int DIG_W = 256,
  parameter int OUT_W = 64,
  parameter int CW    = 8
) (
  input  logic [CW-1:0]    word_cnt,
  input  logic [DIG_W-1:0] ch_mem [T],
  input  logic [DIG_W-1:0] cn_mem [T],
  input  logic [DIG_W-1:0] cv_mem [T],
  output logic [OUT_W-1:0] word
);

  localparam int WPD     = DIG_W / OUT_W;
  localparam int PER_SEL = T * WPD;
  localparam int IDX_W   = (T > 1) ? $clog2(T) : 1;

  int               cnt_i;
  int               rem_i;
  int               wrd_i;
  logic [1:0]       sel;
  logic [IDX_W-1:0] round_idx;
  logic [DIG_W-1:0] dig;

  // Decode counter to array/round/word and select the output slice.
  always_comb begin
    cnt_i     = int'(word_cnt);
    sel       = 2'(cnt_i / PER_SEL);
    rem_i     = cnt_i % PER_SEL;
    round_idx = IDX_W'(rem_i / WPD);
    wrd_i     = rem_i % WPD;
    case (sel)
      2'd0:    dig = ch_mem[round_idx];
      2'd1:    dig = cn_mem[round_idx];
      default: dig = cv_mem[round_idx];
    endcase
    word = OUT_W'(dig >> ((WPD - 1 - wrd_i) * OUT_W));
  end

endmodule

// File: rtl/commit_collector.sv
// Commit collector: gathers per-round Ch/Cn/Cv digest triples arriving in
// any order, then streams them in strict round order as OUT_W words to the
// challenge hash. Build option COLLECT_DUP_CHECK_EN: flag duplicate rounds
// and keep the first write instead of overwriting.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready
// are both high; valid never depends on ready, and out_data/out_last hold
// steady while out_valid is high and out_ready is low.
module commit_collector
  import commit_collector_pkg::*;
#(
  parameter int T     = 16,
  parameter int DIG_W = DIG_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_round,
  input  logic [DIG_W-1:0] in_ch,
  input  logic [DIG_W-1:0] in_cn,
  input  logic [DIG_W-1:0] in_cv,
  output logic             collect_done,
  input  logic             stream_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             stream_end,
  output logic             err_range,
  output logic             err_dup,
  output state_t           dbg_state
);

  localparam int WPD   = DIG_W / OUT_W;
  localparam int NW    = 3 * T * WPD;
  localparam int CW    = word_cnt_w(T, DIG_W, OUT_W);
  localparam int IDX_W = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NW - 1);

  state_t           state;
  state_t           state_next;
  logic             armed;
  logic [T-1:0]     bitmap;
  logic [T-1:0]     set_mask;
  logic [CW-1:0]    word_cnt;
  logic [DIG_W-1:0] ch_mem [T];
  logic [DIG_W-1:0] cn_mem [T];
  logic [DIG_W-1:0] cv_mem [T];
  logic [OUT_W-1:0] sel_word;
  logic [IDX_W-1:0] round_idx;
  logic             in_hs;
  logic             round_ok;
  logic             wr_en;
  logic             out_hs;
  logic             last_word;

  assign round_ok  = int'(in_round) < T;
  assign round_idx = IDX_W'(in_round);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last_word = (word_cnt == LAST_CNT);
  assign set_mask  = (in_hs & round_ok) ? (T'(1) << round_idx) : '0;
  assign dbg_state = state;

`ifdef COLLECT_DUP_CHECK_EN
  logic dup_hit;
  logic err_dup_q;
  // First write wins: an already-present round is flagged, not stored.
  assign dup_hit = in_hs & round_ok & bitmap[round_idx];
  assign wr_en   = in_hs & round_ok & ~clear & ~bitmap[round_idx];
  assign err_dup = err_dup_q;

  // Sticky duplicate flag, flushed by clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          err_dup_q <= 1'b0;
    else if (clear)      err_dup_q <= 1'b0;
    else if (dup_hit)    err_dup_q <= 1'b1;
  end
`else
  assign wr_en   = in_hs & round_ok & ~clear;
  assign err_dup = 1'b0;
`endif

  // Digest storage; contents survive clear and reset by design.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ch_mem[round_idx] <= in_ch;
      cn_mem[round_idx] <= in_cn;
      cv_mem[round_idx] <= in_cv;
    end
  end

  commit_word_sel #(
    .T     (T),
    .DIG_W (DIG_W),
    .OUT_W (OUT_W),
    .CW    (CW)
  ) u_word_sel (
    .word_cnt (word_cnt),
    .ch_mem   (ch_mem),
    .cn_mem   (cn_mem),
    .cv_mem   (cv_mem),
    .word     (sel_word)
  );

  // Control registers: state, bitmap, word counter, pulses and sticky errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_COLLECT;
      armed      <= 1'b0;
      bitmap     <= '0;
      word_cnt   <= '0;
      stream_end <= 1'b0;
      err_range  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (clear) begin
        state      <= ST_COLLECT;
        bitmap     <= '0;
        word_cnt   <= '0;
        stream_end <= 1'b0;
        err_range  <= 1'b0;
      end else begin
        state      <= state_next;
        bitmap     <= bitmap | set_mask;
        stream_end <= out_hs & last_word;
        if (out_hs) word_cnt <= last_word ? '0 : word_cnt + CW'(1);
        if (in_hs & ~round_ok) err_range <= 1'b1;
      end
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    collect_done = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    case (state)
      ST_COLLECT: begin
        in_ready = armed;
        if (&(bitmap | set_mask)) state_next = ST_FULL;
      end
      ST_FULL: begin
        collect_done = 1'b1;
        if (stream_start) state_next = ST_STREAM;
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        out_data  = sel_word;
        out_last  = last_word;
        if (out_hs && last_word) state_next = ST_DONE;
      end
      ST_DONE: begin
        collect_done = 1'b1;
      end
      default: state_next = ST_COLLECT;
    endcase
  end

endmodule

// File: tb/tb_commit_collector.sv
// Directed bench for commit_collector: in-order, reverse-order, range-error,
// duplicate-round, mid-stream stall, mid-stream reset and clear cases.
`timescale 1ns/1ps
module tb_commit_collector;
  import commit_collector_pkg::*;

  localparam int T     = 16;
  localparam int DIG_W = 256;
  localparam int OUT_W = 64;
  localparam int NW    = 192;
`ifdef COLLECT_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_round;
  logic [DIG_W-1:0] in_ch;
  logic [DIG_W-1:0] in_cn;
  logic [DIG_W-1:0] in_cv;
  logic             collect_done;
  logic             stream_start;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             stream_end;
  logic             err_range;
  logic             err_dup;
  state_t           dbg_state;

  commit_collector #(.T(T), .DIG_W(DIG_W), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_round     (in_round),
    .in_ch        (in_ch),
    .in_cn        (in_cn),
    .in_cv        (in_cv),
    .collect_done (collect_done),
    .stream_start (stream_start),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .stream_end   (stream_end),
    .err_range    (err_range),
    .err_dup      (err_dup),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of stored digests
  logic [DIG_W-1:0] m_ch [T];
  logic [DIG_W-1:0] m_cn [T];
  logic [DIG_W-1:0] m_cv [T];
  logic [T-1:0]     m_bit;

  // Scoreboard
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] got [NW];
  logic             got_last [NW];

  typedef struct {
    int              idx;
    logic [OUT_W-1:0] data;
    logic            last;
  } vec_t;
  vec_t vecs [10];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_word(input int i);
    int sel, rem, r, w;
    logic [DIG_W-1:0] d;
    sel = i / (T * 4);
    rem = i % (T * 4);
    r   = rem / 4;
    w   = rem % 4;
    d   = (sel == 0) ? m_ch[r] : (sel == 1) ? m_cn[r] : m_cv[r];
    return d[(3 - w) * OUT_W +: OUT_W];
  endfunction

  // Driver: one triple presented for one cycle, called at a negedge.
  task automatic write_triple(input int r, input logic [DIG_W-1:0] ch,
                              input logic [DIG_W-1:0] cn, input logic [DIG_W-1:0] cv,
                              input bit with_clear);
    in_valid = 1'b1;
    in_round = 8'(r);
    in_ch    = ch;
    in_cn    = cn;
    in_cv    = cv;
    clear    = with_clear;
    check1($sformatf("in_ready_wr%0d", r), in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    if (with_clear) m_bit = '0;
    else if (r < T) begin
      if (!(DUP_EN && m_bit[r])) begin
        m_ch[r] = ch;
        m_cn[r] = cn;
        m_cv[r] = cv;
      end
      m_bit[r] = 1'b1;
    end
  endtask

  task automatic write_std(input int r);
    write_triple(r, DIG_W'(r), DIG_W'(256 + r), DIG_W'(512 + r), 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_bit = '0;
  endtask

  // Driver + monitor for one output stream; optional stall and reset abort.
  task automatic run_stream(input int stall_at, input int abort_at);
    int n, cyc, stall_cnt;
    bit aborted;
    n = 0; cyc = 0; stall_cnt = 0; aborted = 0;
    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_q.push_back(model_word(i));
    out_ready    = 1'b1;
    stream_start = 1'b1;
    check1("ov_before_start", out_valid, 1'b0);
    @(negedge clk);
    stream_start = 1'b0;
    check1("ov_rise", out_valid, 1'b1);
    while (n < NW) begin
      if (cyc > 2000) break;
      if (n == abort_at) begin
        reset = 1'b0;
        #1;
        check1("abort_out_valid", out_valid, 1'b0);
        check64("abort_out_data", 64'(out_data), 64'd0);
        check1("abort_out_last", out_last, 1'b0);
        check1("abort_in_ready", in_ready, 1'b0);
        check1("abort_collect_done", collect_done, 1'b0);
        exp_q.delete();
        m_bit   = '0;
        aborted = 1;
        break;
      end
      check1($sformatf("ov_w%0d", n), out_valid, 1'b1);
      if (out_ready) begin
        check64($sformatf("data_w%0d", n), 64'(out_data), 64'(exp_q.pop_front()));
        check1($sformatf("last_w%0d", n), out_last, (n == NW - 1));
        got[n]      = out_data;
        got_last[n] = out_last;
        n++;
      end else begin
        check64($sformatf("stall_data_w%0d", n), 64'(out_data), 64'(exp_q[0]));
        check1($sformatf("stall_last_w%0d", n), out_last, 1'b0);
      end
      if (n == stall_at && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!aborted) begin
      if (n < NW) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout: got %0d words expected %0d", n, NW);
      end else begin
        check1("end_out_valid", out_valid, 1'b0);
        check1("stream_end_pulse", stream_end, 1'b1);
        @(negedge clk);
        check1("stream_end_drop", stream_end, 1'b0);
        check1("done_collect_done", collect_done, 1'b1);
        check64("done_state", 64'(dbg_state), 64'(ST_DONE));
      end
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      check64($sformatf("%s_vec_w%0d", tag, vecs[i].idx), 64'(got[vecs[i].idx]), 64'(vecs[i].data));
      check1($sformatf("%s_vec_last%0d", tag, vecs[i].idx), got_last[vecs[i].idx], vecs[i].last);
    end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_round = '0;
    in_ch = '0; in_cn = '0; in_cv = '0; stream_start = 1'b0; out_ready = 1'b0;
    m_bit = '0;
    vecs[0] = '{0,   64'h0,   1'b0};
    vecs[1] = '{3,   64'h0,   1'b0};
    vecs[2] = '{7,   64'h1,   1'b0};
    vecs[3] = '{51,  64'hC,   1'b0};
    vecs[4] = '{63,  64'hF,   1'b0};
    vecs[5] = '{67,  64'h100, 1'b0};
    vecs[6] = '{127, 64'h10F, 1'b0};
    vecs[7] = '{131, 64'h200, 1'b0};
    vecs[8] = '{190, 64'h0,   1'b0};
    vecs[9] = '{191, 64'h20F, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_collect_done", collect_done, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check64("rst_out_data", 64'(out_data), 64'd0);
    check1("rst_out_last", out_last, 1'b0);
    check1("rst_stream_end", stream_end, 1'b0);
    check1("rst_err_range", err_range, 1'b0);
    check1("rst_err_dup", err_dup, 1'b0);
    check64("rst_state", 64'(dbg_state), 64'(ST_COLLECT));
    reset = 1'b1;
    check1("in_ready_at_release", in_ready, 1'b0);
    @(negedge clk);
    check1("in_ready_after_release", in_ready, 1'b1);

    // stream_start outside FULL is ignored
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    check1("start_in_collect_ignored", out_valid, 1'b0);
    check64("start_in_collect_state", 64'(dbg_state), 64'(ST_COLLECT));

    // In-order collection, stream with a 5-cycle stall at word 50
    for (int r = 0; r < T - 1; r++) write_std(r);
    check1("fwd_not_done_at_15", collect_done, 1'b0);
    write_std(T - 1);
    check1("fwd_collect_done", collect_done, 1'b1);
    check1("fwd_full_in_ready", in_ready, 1'b0);
    check64("fwd_state_full", 64'(dbg_state), 64'(ST_FULL));
    run_stream(50, -1);
    check_table("fwd");

    // stream_start in DONE is ignored, then clear
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    @(negedge clk);
    check1("start_in_done_ignored", out_valid, 1'b0);
    do_clear();
    check1("clr_in_ready", in_ready, 1'b1);
    check1("clr_collect_done", collect_done, 1'b0);
    check64("clr_state", 64'(dbg_state), 64'(ST_COLLECT));

    // Out-of-range round, then reverse-order collection
    write_triple(16, DIG_W'(64'hDEAD), DIG_W'(64'hBEEF), DIG_W'(64'hF00D), 1'b0);
    check1("range_err_set", err_range, 1'b1);
    check1("range_no_done", collect_done, 1'b0);
    for (int r = T - 1; r >= 1; r--) write_std(r);
    check1("rev_not_done_at_15", collect_done, 1'b0);
    write_std(0);
    check1("rev_collect_done", collect_done, 1'b1);
    check1("rev_err_dup", err_dup, 1'b0);
    check1("rev_err_range_sticky", err_range, 1'b1);
    run_stream(-1, -1);
    check_table("rev");
    do_clear();
    check1("clr_err_range", err_range, 1'b0);

    // Duplicate round 3 (A then B), stream aborted by reset at word 100
    write_triple(3, DIG_W'(64'hA0A0), DIG_W'(64'hB0B0), DIG_W'(64'hC0C0), 1'b0);
    for (int r = 0; r < T; r++) write_std(r);
    check1("dup_collect_done", collect_done, 1'b1);
    check1("dup_err_dup", err_dup, DUP_EN);
    run_stream(-1, 100);
    @(negedge clk);
    reset = 1'b1;
    check1("rel_in_ready_low", in_ready, 1'b0);
    @(negedge clk);
    check1("rel_in_ready", in_ready, 1'b1);
    check1("rel_collect_done", collect_done, 1'b0);
    check1("rel_err_dup", err_dup, 1'b0);
    check64("rel_state", 64'(dbg_state), 64'(ST_COLLECT));

    // Full re-collect; clear beats a simultaneous write of round 0
    write_triple(0, DIG_W'(0), DIG_W'(256), DIG_W'(512), 1'b1);
    for (int r = 1; r < T; r++) write_std(r);
    check1("clear_wins_no_done", collect_done, 1'b0);
    write_std(0);
    check1("recollect_done", collect_done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
